// File: rtl/alu_pipe_hs.sv
// Registered ALU with valid/ready handshakes on both sides, NZCV flags and an
// iterative shift-add multiply that stalls the upstream while it runs.
module alu_pipe_hs #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam int SH = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SH-1:0]    cnt;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;
  logic             is_mul;
  logic             accept;
  logic [WIDTH-1:0] acc_next;

  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    sum     = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    is_mul  = MUL_EN && (alu_op == 4'd5);
    case (alu_op)
      4'd0: alu_res = a & b;
      4'd1: alu_res = a | b;
      4'd2: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3: alu_res = a << b[SH-1:0];
      4'd4: alu_res = a >> b[SH-1:0];
      // MUL result comes from the iterative path; only flag illegality here
      4'd5: alu_err = !MUL_EN;
      4'd6: begin
        sum     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd7:  alu_res = b;
      4'd12: alu_res = ~(a | b);
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (is_mul) begin
              state     <= MUL;
              out_valid <= 1'b0;
              mcand     <= a;
              mplier    <= b;
              acc       <= '0;
              cnt       <= '0;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              result    <= alu_res;
              flag_n    <= alu_res[WIDTH-1];
              flag_z    <= (alu_res == '0);
              flag_c    <= alu_c;
              flag_v    <= alu_v;
              err       <= alu_err;
            end
          end else if ((state == HOLD) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SH'(1);
          // last iteration: publish the sum including this cycle's partial product
          if (cnt == SH'(WIDTH-1)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            result    <= acc_next;
            flag_n    <= acc_next[WIDTH-1];
            flag_z    <= (acc_next == '0);
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            err       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Bench for alu_pipe_hs: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level reference model.
module tb_alu_pipe_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  alu_op;
  logic [63:0] a, b, result;
  logic        flag_n, flag_z, flag_c, flag_v, err;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [3:0]  n_alu_op;
  logic [63:0] n_a, n_b, n_result;
  logic        n_flag_n, n_flag_z, n_flag_c, n_flag_v, n_err;

  always #5 clk = ~clk;

  alu_pipe_hs #(.WIDTH(64), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v), .err(err)
  );

  alu_pipe_hs #(.WIDTH(64), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .alu_op(n_alu_op), .a(n_a), .b(n_b), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .result(n_result), .flag_n(n_flag_n), .flag_z(n_flag_z), .flag_c(n_flag_c),
    .flag_v(n_flag_v), .err(n_err)
  );

  typedef struct packed {
    logic [63:0] res;
    logic        n, z, c, v, e;
  } res_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model state: what the DUT should be presenting
  bit   started = 0;
  bit   have    = 0;
  bit   zeroed  = 0;
  int   mul_left = 0;
  res_t cur     = '0;
  res_t mul_res = '0;

  function automatic res_t ref_op(input logic [3:0] op, input logic [63:0] x,
                                  input logic [63:0] y, input bit mul_en);
    res_t r;
    logic signed [64:0] s;
    int unsigned sh;
    r  = '0;
    s  = '0;
    sh = int'(y[5:0]);
    case (op)
      4'd0: r.res = x & y;
      4'd1: r.res = x | y;
      4'd2: begin
        r.res = x + y;
        r.c   = (r.res < x);
        s     = $signed({x[63], x}) + $signed({y[63], y});
        r.v   = (s[64] != s[63]);
      end
      4'd3: r.res = x << sh;
      4'd4: r.res = x >> sh;
      4'd5: if (mul_en) r.res = x * y; else r.e = 1'b1;
      4'd6: begin
        r.res = x - y;
        r.c   = (x >= y);
        s     = $signed({x[63], x}) - $signed({y[63], y});
        r.v   = (s[64] != s[63]);
      end
      4'd7:  r.res = y;
      4'd12: r.res = ~(x | y);
      default: r.e = 1'b1;
    endcase
    r.n = r.res[63];
    r.z = (r.res == 64'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [63:0] x,
                       input logic [63:0] y, input bit ordy);
    in_valid = v; alu_op = op; a = x; b = y; out_ready = ordy;
  endtask

  // One clock: compare DUT against the model at the negedge, advance the model
  // through the coming posedge, then return 1 time unit after it.
  task automatic tick();
    bit   exp_rdy;
    res_t r;
    @(negedge clk);
    exp_rdy = (mul_left == 0) && (!have || out_ready);
    if (started) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      chk("out_valid", {63'd0, out_valid}, {63'd0, have});
      if (have || zeroed) begin
        chk("result", result, cur.res);
        chk("flags_nzcve", {59'd0, flag_n, flag_z, flag_c, flag_v, err},
            {59'd0, cur.n, cur.z, cur.c, cur.v, cur.e});
      end
    end
    if (!rst_n) begin
      have = 0; mul_left = 0; cur = '0; zeroed = 1; started = 1;
    end else begin
      if (have && out_ready) have = 0;
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin have = 1; cur = mul_res; zeroed = 0; end
      end else if (exp_rdy && in_valid) begin
        r = ref_op(alu_op, a, b, 1'b1);
        if (alu_op == 4'd5) begin
          mul_left = 64; mul_res = r;
        end else begin
          have = 1; cur = r; zeroed = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [3:0]  op;
    logic [63:0] r2;
    rst_n = 1'b0;
    drive(1'b1, 4'd2, 64'd1, 64'd1, 1'b1);
    n_in_valid = 1'b0; n_alu_op = 4'd0; n_a = '0; n_b = '0; n_out_ready = 1'b1;

    // reset with an op offered: must not be accepted
    repeat (3) tick();
    rst_n = 1'b1;
    drive(1'b0, 4'd0, '0, '0, 1'b1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick();

    // ADD overflow
    drive(1'b1, 4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    tick();
    drive(1'b0, 4'd0, '0, '0, 1'b1);
    chk("add_model", cur.res, 64'h8000_0000_0000_0000);
    chk("add_res", result, 64'h8000_0000_0000_0000);
    chk("add_flags", {59'd0, flag_n, flag_z, flag_c, flag_v, err}, 64'b10010);
    tick();

    // SUB equal, then SUB borrow back-to-back
    drive(1'b1, 4'd6, 64'd5, 64'd5, 1'b1);
    tick();
    chk("sub_eq_flags", {59'd0, flag_n, flag_z, flag_c, flag_v, err}, 64'b01100);
    drive(1'b1, 4'd6, 64'd0, 64'd1, 1'b1);
    tick();
    chk("sub_borrow_res", result, '1);
    chk("sub_borrow_flags", {59'd0, flag_n, flag_z, flag_c, flag_v, err}, 64'b10000);
    drive(1'b0, 4'd0, '0, '0, 1'b1);
    tick();

    // MUL 3*7 with an AND held offered during the multiply
    drive(1'b1, 4'd5, 64'd3, 64'd7, 1'b1);
    tick();
    drive(1'b1, 4'd0, 64'hF0F0, 64'h0FF0, 1'b1);
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) chk("mul_not_yet", {63'd0, out_valid}, 64'd0);
    end
    chk("mul_valid", {63'd0, out_valid}, 64'd1);
    chk("mul_res", result, 64'd21);
    tick();
    drive(1'b1, 4'd5, '1, 64'd2, 1'b1);
    tick();
    drive(1'b0, 4'd0, '0, '0, 1'b1);
    repeat (64) tick();
    chk("mul_neg_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mul_model", cur.res, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();

    // streaming, then backpressure for 3 cycles
    drive(1'b1, 4'd0, 64'hFF00, 64'h0FF0, 1'b1); tick();
    drive(1'b1, 4'd1, 64'hFF00, 64'h0FF0, 1'b1); tick();
    chk("or_res", result, 64'hFFF0);
    drive(1'b1, 4'd3, 64'd1, 64'h41, 1'b1); tick();
    chk("lsl_res", result, 64'd2);
    drive(1'b1, 4'd4, 64'h8000_0000_0000_0000, 64'd63, 1'b1); tick();
    chk("lsr_res", result, 64'd1);
    drive(1'b1, 4'd7, 64'd9, 64'h1234, 1'b0); tick();
    r2 = result;
    drive(1'b1, 4'd12, 64'd0, 64'd0, 1'b0);
    repeat (3) tick();
    chk("stall_frozen", result, r2);
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1; tick();
    chk("nor_res", result, '1);
    drive(1'b0, 4'd0, '0, '0, 1'b1); tick();

    // illegal opcode, and MUL on the MUL_EN=0 instance
    drive(1'b1, 4'd9, 64'd3, 64'd4, 1'b1);
    n_in_valid = 1'b1; n_alu_op = 4'd5; n_a = 64'd3; n_b = 64'd7;
    tick();
    chk("illegal_flags", {59'd0, flag_n, flag_z, flag_c, flag_v, err}, 64'b01001);
    chk("illegal_res", result, 64'd0);
    chk("nomul_valid", {63'd0, n_out_valid}, 64'd1);
    chk("nomul_res", n_result, 64'd0);
    chk("nomul_flags", {59'd0, n_flag_n, n_flag_z, n_flag_c, n_flag_v, n_err}, 64'b01001);
    n_alu_op = 4'd6; n_a = 64'd3; n_b = 64'd7;
    drive(1'b0, 4'd0, '0, '0, 1'b1);
    tick();
    chk("nomul_sub_res", n_result, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("nomul_sub_flags", {59'd0, n_flag_n, n_flag_z, n_flag_c, n_flag_v, n_err}, 64'b10000);
    n_in_valid = 1'b0;
    tick();

    // reset in the middle of a multiply
    drive(1'b1, 4'd5, 64'd11, 64'd13, 1'b1); tick();
    drive(1'b0, 4'd0, '0, '0, 1'b1);
    repeat (20) tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("midmul_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("midmul_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("midmul_rst_res", result, 64'd0);
    drive(1'b1, 4'd2, 64'd40, 64'd2, 1'b1); tick();
    chk("post_rst_add", result, 64'd42);
    drive(1'b0, 4'd0, '0, '0, 1'b1); tick();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd5 && $urandom_range(0, 3) != 0) op = 4'd2;
      if (op > 4'd7 && op != 4'd12 && $urandom_range(0, 3) != 0) op = 4'd6;
      drive(($urandom_range(0, 3) != 0), op, pick(), pick(), ($urandom_range(0, 3) != 0));
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    drive(1'b0, 4'd0, '0, '0, 1'b1);
    repeat (70) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
